// File: rtl/sum_accumulator.sv
// Batch accumulator: adds COUNT 17-bit sums from the upstream adder and presents the total.
// Optional macro ACC_SATURATE_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int COUNT = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [16:0]      sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic [1:0]       o_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(COUNT);

    generate
        if (COUNT < 1 || COUNT > 255) begin : g_bad_count
            $error("sum_accumulator: COUNT must be in 1..255");
        end
        if (ACC_W < 17) begin : g_bad_width
            $error("sum_accumulator: ACC_W must be at least 17");
        end
    endgenerate

    state_t           r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;

    logic             w_accept;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_add;
    logic [7:0]       w_cnt_inc;

    // Both ports are valid/ready: a word moves on a rising edge where valid and ready are
    // both 1; the producer holds its data while ready is 0, and ready never looks at valid.
    assign w_accept  = in_valid & in_ready;

    assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(sum_in);
    assign w_carry   = w_sum[ACC_W];
    assign w_cnt_inc = r_cnt + 8'd1;

`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero add carries again, so the value stays pinned.
    assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_add = w_sum[ACC_W-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = ACC_W'(sum_in);
                    w_cnt_nxt   = 8'd1;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = (COUNT == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_acc_add;
                    w_cnt_nxt = w_cnt_inc;
                    w_ovf_nxt = r_ovf | w_carry;
                    if (w_cnt_inc == CNT_LAST) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign in_ready  = (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;
    assign o_state   = r_state;

    // A presented result must not move until the consumer takes it.
    a_done_stable: assert property (@(posedge clk) disable iff (rst)
        (r_state == DONE && !out_ready) |=> ($stable(r_acc) && $stable(r_ovf) && r_state == DONE));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (r_cnt <= CNT_LAST));

    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        (r_state == IDLE || r_state == ACCUM || r_state == DONE));

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed, table-driven bench for sum_accumulator using four instances with different
// COUNT/ACC_W settings; expectations follow ACC_SATURATE_EN when that macro is defined.
module tb_sum_accumulator;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // unit 0: COUNT=4 ACC_W=24, unit 1: COUNT=3, unit 2: COUNT=4 ACC_W=18, unit 3: COUNT=1
    logic        iv[4];
    logic        ordy[4];
    logic [16:0] sin[4];
    logic        ov[4];
    logic        ir[4];
    logic        of[4];
    logic [1:0]  st[4];
    logic [23:0] acc_a, acc_b, acc_d;
    logic [17:0] acc_c;

    sum_accumulator #(.COUNT(4), .ACC_W(24)) u_a (
        .clk(clk), .rst(rst), .sum_in(sin[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .acc_out(acc_a), .out_valid(ov[0]), .out_ready(ordy[0]), .ovf(of[0]), .o_state(st[0]));
    sum_accumulator #(.COUNT(3), .ACC_W(24)) u_b (
        .clk(clk), .rst(rst), .sum_in(sin[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .acc_out(acc_b), .out_valid(ov[1]), .out_ready(ordy[1]), .ovf(of[1]), .o_state(st[1]));
    sum_accumulator #(.COUNT(4), .ACC_W(18)) u_c (
        .clk(clk), .rst(rst), .sum_in(sin[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .acc_out(acc_c), .out_valid(ov[2]), .out_ready(ordy[2]), .ovf(of[2]), .o_state(st[2]));
    sum_accumulator #(.COUNT(1), .ACC_W(24)) u_d (
        .clk(clk), .rst(rst), .sum_in(sin[3]), .in_valid(iv[3]), .in_ready(ir[3]),
        .acc_out(acc_d), .out_valid(ov[3]), .out_ready(ordy[3]), .ovf(of[3]), .o_state(st[3]));

    typedef struct {
        int          unit;
        logic        iv;
        logic [16:0] sum;
        logic        ordy;
        logic [23:0] eacc;
        logic        eov;
        logic        eir;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_seg1;
    int   n_seg2;

`ifdef ACC_SATURATE_EN
    localparam logic [23:0] OVF_ACC3 = 24'd262143;
    localparam logic [23:0] OVF_ACC4 = 24'd262143;
`else
    localparam logic [23:0] OVF_ACC3 = 24'd131069;
    localparam logic [23:0] OVF_ACC4 = 24'd262140;
`endif

    function automatic logic [23:0] get_acc(input int u);
        case (u)
            0:       return acc_a;
            1:       return acc_b;
            2:       return {6'd0, acc_c};
            default: return acc_d;
        endcase
    endfunction

    function automatic void add(input int u, input logic v, input logic [16:0] s, input logic r,
                                input logic [23:0] ea, input logic eo, input logic ei,
                                input logic ef);
        vec_t t;
        t = '{unit: u, iv: v, sum: s, ordy: r, eacc: ea, eov: eo, eir: ei, eovf: ef};
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_all(input string tag);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("%s u%0d acc", tag, u), {8'd0, get_acc(u)}, 32'd0);
            check($sformatf("%s u%0d out_valid", tag, u), {31'd0, ov[u]}, 32'd0);
            check($sformatf("%s u%0d ovf", tag, u), {31'd0, of[u]}, 32'd0);
            check($sformatf("%s u%0d state", tag, u), {30'd0, st[u]}, 32'd0);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 4; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
            sin[k]  = '0;
        end
    endtask

    // Drive one vector for a full clock, then compare just after the edge.
    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            clear_inputs();
            iv[tbl[i].unit]   = tbl[i].iv;
            sin[tbl[i].unit]  = tbl[i].sum;
            ordy[tbl[i].unit] = tbl[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d u%0d acc", i, tbl[i].unit), {8'd0, get_acc(tbl[i].unit)},
                  {8'd0, tbl[i].eacc});
            check($sformatf("v%0d u%0d out_valid", i, tbl[i].unit), {31'd0, ov[tbl[i].unit]},
                  {31'd0, tbl[i].eov});
            check($sformatf("v%0d u%0d in_ready", i, tbl[i].unit), {31'd0, ir[tbl[i].unit]},
                  {31'd0, tbl[i].eir});
            check($sformatf("v%0d u%0d ovf", i, tbl[i].unit), {31'd0, of[tbl[i].unit]},
                  {31'd0, tbl[i].eovf});
        end
        clear_inputs();
    endtask

    initial begin
        // unit 0: basic batch 17+24+27+37 = 105, one-cycle out_valid
        add(0, 1, 17, 1, 17, 0, 1, 0);
        add(0, 1, 24, 1, 41, 0, 1, 0);
        add(0, 1, 27, 1, 68, 0, 1, 0);
        add(0, 1, 37, 1, 105, 1, 0, 0);
        add(0, 0, 0, 1, 105, 0, 1, 0);
        add(0, 0, 0, 0, 105, 0, 1, 0);
        // unit 0: same batch under backpressure with 63 waiting upstream
        add(0, 1, 17, 0, 17, 0, 1, 0);
        add(0, 1, 24, 0, 41, 0, 1, 0);
        add(0, 1, 27, 0, 68, 0, 1, 0);
        add(0, 1, 37, 0, 105, 1, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 63, 0, 105, 1, 0, 0);
        add(0, 1, 63, 1, 105, 0, 1, 0);
        add(0, 1, 63, 0, 63, 0, 1, 0);
        add(0, 1, 1, 0, 64, 0, 1, 0);
        // unit 1: bubbles, 132+158+174 = 464
        add(1, 1, 132, 0, 132, 0, 1, 0);
        add(1, 0, 0, 0, 132, 0, 1, 0);
        add(1, 0, 0, 0, 132, 0, 1, 0);
        add(1, 1, 158, 0, 290, 0, 1, 0);
        add(1, 0, 0, 0, 290, 0, 1, 0);
        add(1, 0, 0, 0, 290, 0, 1, 0);
        add(1, 1, 174, 0, 464, 1, 0, 0);
        add(1, 0, 0, 0, 464, 1, 0, 0);
        add(1, 0, 0, 1, 464, 0, 1, 0);
        // unit 2: overflow at 18 bits, then sticky ovf cleared by the next IDLE accept
        add(2, 1, 17'd131071, 0, 131071, 0, 1, 0);
        add(2, 1, 17'd131071, 0, 262142, 0, 1, 0);
        add(2, 1, 17'd131071, 0, OVF_ACC3, 0, 1, 1);
        add(2, 1, 17'd131071, 0, OVF_ACC4, 1, 0, 1);
        add(2, 0, 0, 1, OVF_ACC4, 0, 1, 1);
        add(2, 1, 5, 0, 5, 0, 1, 0);
        // unit 3: COUNT=1, back-to-back batches one clock apart
        add(3, 1, 17'd65535, 0, 65535, 1, 0, 0);
        add(3, 1, 2, 1, 65535, 0, 1, 0);
        add(3, 1, 2, 1, 2, 1, 0, 0);
        add(3, 0, 0, 1, 2, 0, 1, 0);
        n_seg1 = tbl.size();
        // unit 0 after mid-batch reset: 8+9+11+13 = 41, left pending in DONE
        add(0, 1, 8, 0, 8, 0, 1, 0);
        add(0, 1, 9, 0, 17, 0, 1, 0);
        add(0, 1, 11, 0, 28, 0, 1, 0);
        add(0, 1, 13, 0, 41, 1, 0, 0);
        n_seg2 = tbl.size();

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_all("por");
        #2 rst = 1'b0;

        run_tbl(0, n_seg1);

        // Reset between edges while unit 0 holds 2 of 4 sums: must clear without a clock.
        #2 rst = 1'b1;
        #1;
        check_reset_all("rst_mid");
        @(posedge clk);
        #1;
        check_reset_all("rst_hold");
        #1 rst = 1'b0;

        run_tbl(n_seg1, n_seg2);

        // Reset while unit 0 presents a pending result.
        #2 rst = 1'b1;
        #1;
        check_reset_all("rst_done");
        for (int u = 0; u < 4; u++) begin
            check($sformatf("rst_done u%0d in_ready", u), {31'd0, ir[u]}, 32'd1);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        // The first edge after release must accept.
        iv[0]  = 1'b1;
        sin[0] = 17'd7;
        @(posedge clk);
        #1;
        check("first_edge acc", {8'd0, acc_a}, 32'd7);
        check("first_edge state", {30'd0, st[0]}, 32'd1);
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
